uart_rx_unit: RTL and testbench
===============================

# uart_rx_unit

Serial receive stage that turns the board's `uart_in` pin into bytes for the CPU. It sits between the pin and the memory-unit I/O register map. It raises `uart_rx_interrupt`, which is wired to CPU `int3`, once per received byte. Format is 8N1 at a fixed baud rate set by a clock-divider parameter, with a single-byte holding register and sticky error flags.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per bit (50 MHz / 115200). Legal range 8..65535.
- `clk`  in  1: system clock, 50 MHz.
- `reset`  in  1: asynchronous, active-high. The top level drives it as `~nreset_stable`.
- `uart_in`  in  1: raw RX pin, asynchronous, idle high.
- `rx_data`  out  8: last received byte. Reset value 8'h00.
- `rx_valid`  out  1: holding register holds an unread byte. Reset value 0.
- `rx_read`  in  1: one-cycle pop strobe from the memory unit; clears `rx_valid`.
- `uart_rx_interrupt`  out  1: one-cycle pulse per byte accepted. Reset value 0.
- `overrun`  out  1: sticky; a byte completed while `rx_valid`=1 and no `rx_read` occurred that cycle. Reset value 0.
- `framing_error`  out  1: sticky; the stop bit was sampled low. Reset value 0.
- `clear_errors`  in  1: one-cycle strobe; clears `overrun` and `framing_error`.

## Operation
- **Input synchronizer:** two flops, both reset to 1, produce `rx_s`. A third flop `rx_prev`, also reset to 1, supports falling-edge detection.
- **Bit-time counter:** 16-bit `cnt` and 3-bit `bitidx`, both reset to 0. `shreg[7:0]` resets to 0.
- **State machine:** IDLE, START, DATA, STOP. Reset state is IDLE.
  - IDLE: when `rx_s`=0 and `rx_prev`=1, go to START with `cnt`=0.
  - START: when `cnt` == CLKS_PER_BIT/2−1, sample `rx_s`. If 0, go to DATA with `cnt`=0 and `bitidx`=0. If 1, the start was a glitch: go to IDLE with no flag set.
  - DATA: when `cnt` == CLKS_PER_BIT−1, sample `rx_s` into `shreg` LSB-first (shift right, new bit in at [7]) and reset `cnt`. After `bitidx`==7 is sampled, go to STOP.
  - STOP: when `cnt` == CLKS_PER_BIT−1, sample `rx_s`. If 1, the byte is accepted. If 0, set `framing_error`, discard the byte and go to IDLE. A held-low break does not retrigger, because IDLE requires a fresh falling edge.
- **Accept action (same edge as the stop sample):**
  - `rx_data` ← `shreg`.
  - `rx_valid` ← 1.
  - `uart_rx_interrupt` ← 1 for exactly that cycle.
  - If `rx_valid` was 1 and `rx_read`=0 on that cycle, set `overrun`. The new byte overwrites the old one.
- **`rx_read`:** clears `rx_valid` next edge. A read with `rx_valid`=0 is ignored. If a read and an accept happen in the same cycle, the accept wins: `rx_valid` stays 1, the new byte is loaded, and `overrun` is not set.
- **`clear_errors`:** if it coincides with an error event, the event wins and the flag ends up set.
- **Reset mid-frame:** returns everything to reset values immediately. A partial frame is lost, and the next byte requires a new falling edge.
- **Counter width:** `cnt` compares against constants derived from `CLKS_PER_BIT`. CLKS_PER_BIT/2 uses integer division.

## Timing
- **Synchronizer latency:** 2 cycles from a pin change to `rx_s`, plus ±1 cycle of phase uncertainty.
- **Sample points:** each data bit is sampled at (CLKS_PER_BIT/2 + k·CLKS_PER_BIT) cycles after START entry, for k = 1..8. The stop bit is sampled at k = 9.
- **Accept latency:** `uart_rx_interrupt` and `rx_valid` rise at 9·CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 cycles (±1) after the pin's falling start edge.
- **Back-to-back frames:** after the accept, the FSM is in IDLE on the next cycle. This leaves half a bit time of margin before the next start edge, so back-to-back frames with one stop bit are received.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package:** FSM state encoding (2-bit localparams) and `UART_DEFAULT_CLKS_PER_BIT` = 434, shared with the future TX block.
- **Sub-modules:** none. The synchronizer is inline, because it must reset to 1 rather than 0.
- **Integration:** the top level ties `uart_rx_interrupt` to CPU `int3`. The memory unit maps `rx_data`/`rx_valid`/flags and generates `rx_read` on a data-register read.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- **Basic byte:** send 8'hA5 (8N1, correct baud) → one-cycle `uart_rx_interrupt` at 155±1 cycles after the start edge; `rx_data`=A5, `rx_valid`=1, flags 0.
- **Glitch rejection:** a low pulse of 4 cycles on an idle line → no interrupt, state back to IDLE, `rx_valid` stays 0.
- **Framing error:** send 8'h3C with the stop bit low, then hold the line low for 40 cycles → `framing_error`=1, `rx_valid`=0, no interrupt, no second frame detected. Then send 8'h01 → `rx_data`=01.
- **Overrun:** send 8'h11 then 8'h22 back-to-back without `rx_read` → two interrupts, `rx_data`=22, `overrun`=1. `clear_errors` → `overrun`=0.
- **Read/accept collision:** assert `rx_read` on the exact accept cycle of the second byte → `rx_valid` stays 1, `rx_data`=new byte, `overrun`=0.
- **Reset mid-frame:** assert `reset` at bit 4 of 8'hFF → all outputs 0, FSM in IDLE. The following 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_rx_unit_pkg.sv
// Shared UART definitions: FSM state encoding and default baud divider.
// The TX block will import the same encoding.
package uart_rx_unit_pkg;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with a single-byte holding register, a per-byte interrupt
// pulse and sticky overrun/framing error flags.
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_read,
  output logic              uart_rx_interrupt,
  output logic              overrun,
  output logic              framing_error,
  input  logic              clear_errors
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic              rx_meta;
  logic              rx_s;
  logic              rx_prev;
  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bitidx;
  logic [DATA_W-1:0] shreg;

  // Pin synchronizer; resets to the idle-high line level so reset release
  // never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Frame FSM plus holding register; later assignments in the same edge
  // override earlier ones, so accept beats read and error events beat clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      bitidx            <= '0;
      shreg             <= '0;
      rx_data           <= '0;
      rx_valid          <= 1'b0;
      uart_rx_interrupt <= 1'b0;
      overrun           <= 1'b0;
      framing_error     <= 1'b0;
    end else begin
      uart_rx_interrupt <= 1'b0;
      if (rx_read) begin
        rx_valid <= 1'b0;
      end
      if (clear_errors) begin
        overrun       <= 1'b0;
        framing_error <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s && rx_prev) begin
            state <= S_START;
            cnt   <= '0;
          end
        end

        S_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state  <= S_DATA;
              bitidx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt    <= '0;
            shreg  <= {rx_s, shreg[DATA_W-1:1]};
            bitidx <= bitidx + IDX_W'(1);
            if (bitidx == IDX_W'(7)) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (rx_s) begin
              rx_data           <= shreg;
              rx_valid          <= 1'b1;
              uart_rx_interrupt <= 1'b1;
              if (rx_valid && !rx_read) begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Randomized and directed checks of uart_rx_unit against a byte-level
// model of the line protocol and holding-register behaviour.
module tb_uart_rx_unit;

  localparam int unsigned CPB = 16;
  localparam int unsigned ACCEPT_LAT = 9 * CPB + CPB / 2 + 3;

  logic       clk;
  logic       reset;
  logic       uart_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read;
  logic       uart_rx_interrupt;
  logic       overrun;
  logic       framing_error;
  logic       clear_errors;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned start_cyc = 0;
  int unsigned irq_cnt  = 0;
  logic [7:0]  exp_q[$];

  uart_rx_unit #(.CLKS_PER_BIT(CPB)) dut (
    .clk               (clk),
    .reset             (reset),
    .uart_in           (uart_in),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_read           (rx_read),
    .uart_rx_interrupt (uart_rx_interrupt),
    .overrun           (overrun),
    .framing_error     (framing_error),
    .clear_errors      (clear_errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drives one frame; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic good);
    if (good) exp_q.push_back(b);
    start_cyc = cyc;
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_in = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pulse_read();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
  endtask

  // Every interrupt must correspond to the oldest good frame sent.
  always @(negedge clk) begin
    if (!reset && uart_rx_interrupt) begin
      int unsigned d;
      logic [7:0] eb;
      irq_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_irq", 32'd1, 32'd0);
      end else begin
        eb = exp_q.pop_front();
        d  = cyc - start_cyc;
        check("irq_data", 32'(rx_data), 32'(eb));
        check("irq_valid", 32'(rx_valid), 32'd1);
        check("irq_latency", ((d >= ACCEPT_LAT - 1) && (d <= ACCEPT_LAT + 1)) ? ACCEPT_LAT : d,
              ACCEPT_LAT);
      end
    end
  end

  initial begin
    int unsigned saved;
    logic [7:0]  b;
    logic        model_valid;
    logic        model_ovr;

    reset = 1'b1; uart_in = 1'b1; rx_read = 1'b0; clear_errors = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_irq", 32'(uart_rx_interrupt), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // basic byte
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("basic_data", 32'(rx_data), 32'hA5);
    check("basic_valid", 32'(rx_valid), 32'd1);
    check("basic_ovr", 32'(overrun), 32'd0);
    check("basic_fe", 32'(framing_error), 32'd0);
    check("basic_irqs", irq_cnt, 32'd1);
    pulse_read();
    check("read_clears", 32'(rx_valid), 32'd0);

    // glitch rejection
    saved = irq_cnt;
    uart_in = 1'b0;
    repeat (4) @(negedge clk);
    uart_in = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_irqs", irq_cnt, saved);
    check("glitch_valid", 32'(rx_valid), 32'd0);

    // framing error followed by held-low break
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    uart_in = 1'b1;
    repeat (20) @(negedge clk);
    check("fe_flag", 32'(framing_error), 32'd1);
    check("fe_valid", 32'(rx_valid), 32'd0);
    check("fe_irqs", irq_cnt, saved);
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("after_fe_data", 32'(rx_data), 32'h01);
    check("fe_sticky", 32'(framing_error), 32'd1);
    pulse_clear();
    check("fe_cleared", 32'(framing_error), 32'd0);
    pulse_read();

    // overrun with back-to-back frames
    saved = irq_cnt;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_irqs", irq_cnt, saved + 2);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_flag", 32'(overrun), 32'd1);
    pulse_clear();
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_valid_kept", 32'(rx_valid), 32'd1);

    // read on the exact accept cycle while a byte is already held
    fork
      send_frame(8'h77, 1'b1, 1'b1);
      begin
        repeat (ACCEPT_LAT - 1) @(negedge clk);
        pulse_read();
      end
    join
    repeat (4) @(negedge clk);
    check("coll_valid", 32'(rx_valid), 32'd1);
    check("coll_data", 32'(rx_data), 32'h77);
    check("coll_ovr", 32'(overrun), 32'd0);

    // reset in the middle of bit 4
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("postrst_valid", 32'(rx_valid), 32'd0);
    check("postrst_ovr", 32'(overrun), 32'd0);
    check("postrst_fe", 32'(framing_error), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("postrst_data", 32'(rx_data), 32'h5A);
    pulse_read();

    // random stream with random reads and gaps
    model_valid = 1'b0;
    model_ovr   = 1'b0;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b1);
      if (model_valid) model_ovr = 1'b1;
      model_valid = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        model_valid = 1'b0;
      end
      check("rnd_valid", 32'(rx_valid), 32'(model_valid));
      check("rnd_ovr", 32'(overrun), 32'(model_ovr));
      if (model_ovr && $urandom_range(0, 3) == 0) begin
        pulse_clear();
        model_ovr = 1'b0;
        check("rnd_clr", 32'(overrun), 32'd0);
      end
      repeat ($urandom_range(0, 2) * CPB / 2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_fe", 32'(framing_error), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
